// File: rtl/traffic_lamp_pkg.sv
// Shared types and constants for the multi-approach traffic-lamp sequencer.
// Optional pedestrian walk phase is enabled by defining TRAFFIC_PED_EN.
package traffic_lamp_pkg;

  // Controller state; its encoding is also the externally visible phase code.
  typedef enum logic [2:0] {
    S_ALLRED = 3'd0,
    S_GREEN  = 3'd1,
    S_YELLOW = 3'd2,
    S_FLASH  = 3'd3,
    S_WALK   = 3'd4
  } phase_t;

  // Per-approach lamp encodings: {red, green, yellow}.
  localparam logic [2:0] LAMP_RED    = 3'b100;
  localparam logic [2:0] LAMP_GREEN  = 3'b010;
  localparam logic [2:0] LAMP_YELLOW = 3'b001;
  localparam logic [2:0] LAMP_OFF    = 3'b000;

  // Larger of two elaboration-time integers, used to size the dwell counter.
  function automatic int max_int(input int a, input int b);
    if (a > b) begin
      return a;
    end else begin
      return b;
    end
  endfunction

endpackage

// File: rtl/traffic_lamp_seq_dwell_timer.sv
// Dwell counter for the traffic-lamp sequencer. Reloads on state entry,
// counts down on ticks and flags the tick on which the dwell expires.
module dwell_timer #(
  parameter int                CNT_W   = 4,
  parameter logic [CNT_W-1:0]  RST_VAL = {CNT_W{1'b0}}
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_tick,
  output logic             o_done
);

  logic [CNT_W-1:0] r_cnt;

  // Countdown register: reload wins, then tick-gated decrement, parked at zero.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_cnt <= RST_VAL;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_tick && (r_cnt != {CNT_W{1'b0}})) begin
      r_cnt <= r_cnt - {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign o_done = (r_cnt == {CNT_W{1'b0}}) & i_tick;

endmodule

// File: rtl/traffic_lamp_seq.sv
// Multi-approach traffic-lamp sequencer: round-robin GREEN -> YELLOW -> ALL-RED
// per approach, with flash override. Define TRAFFIC_PED_EN to add the
// pedestrian walk phase (i_ped_req / o_walk ports and the S_WALK state).
module traffic_lamp_seq
  import traffic_lamp_pkg::*;
#(
  parameter int NUM_DIR      = 4,
  parameter int GREEN_TICKS  = 20,
  parameter int YELLOW_TICKS = 4,
  parameter int ALLRED_TICKS = 2,
  parameter int WALK_TICKS   = 10,
  localparam int DIR_W       = $clog2(NUM_DIR)
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic                 i_tick,
  input  logic                 i_flash,
  output logic [3*NUM_DIR-1:0] o_light,
  output logic [DIR_W-1:0]     o_active_dir,
  output logic [2:0]           o_phase
`ifdef TRAFFIC_PED_EN
  ,
  input  logic                 i_ped_req,
  output logic                 o_walk
`endif
);

  localparam int MAX_DUR = max_int(max_int(GREEN_TICKS, YELLOW_TICKS),
                                   max_int(ALLRED_TICKS, WALK_TICKS));
  localparam int CNT_W   = $clog2(MAX_DUR) + 1;

  // Reload values are duration-1 so a phase spans exactly its tick count.
  localparam logic [CNT_W-1:0] GREEN_LD  = CNT_W'(GREEN_TICKS - 1);
  localparam logic [CNT_W-1:0] YELLOW_LD = CNT_W'(YELLOW_TICKS - 1);
  localparam logic [CNT_W-1:0] ALLRED_LD = CNT_W'(ALLRED_TICKS - 1);
`ifdef TRAFFIC_PED_EN
  localparam logic [CNT_W-1:0] WALK_LD   = CNT_W'(WALK_TICKS - 1);
`endif
  localparam logic [DIR_W-1:0] LAST_DIR  = DIR_W'(NUM_DIR - 1);

  phase_t               r_state;
  phase_t               w_next_state;
  logic [DIR_W-1:0]     r_dir;
  logic [DIR_W-1:0]     w_next_dir;
  logic [DIR_W-1:0]     w_inc_dir;
  logic                 r_blink;
  logic                 w_next_blink;
  logic                 w_load;
  logic [CNT_W-1:0]     w_load_val;
  logic                 w_done;
  logic [3*NUM_DIR-1:0] r_light;
`ifdef TRAFFIC_PED_EN
  logic                 r_ped_pending;
  logic                 r_walk;
`endif

  // Lamp pattern for a given state/approach/blink; evaluated on next-state values.
  function automatic logic [3*NUM_DIR-1:0] decode_light(input phase_t st,
                                                        input logic [DIR_W-1:0] d,
                                                        input logic bl);
    logic [3*NUM_DIR-1:0] res;
    logic [2:0]           lamp;
    res = {(3*NUM_DIR){1'b0}};
    for (int i = 0; i < NUM_DIR; i++) begin
      case (st)
        S_GREEN:  lamp = (d == DIR_W'(i)) ? LAMP_GREEN : LAMP_RED;
        S_YELLOW: lamp = (d == DIR_W'(i)) ? LAMP_YELLOW : LAMP_RED;
        S_FLASH:  lamp = bl ? LAMP_YELLOW : LAMP_OFF;
        default:  lamp = LAMP_RED;
      endcase
      res[3*i +: 3] = lamp;
    end
    return res;
  endfunction

  assign w_inc_dir = (r_dir == LAST_DIR) ? {DIR_W{1'b0}} : (r_dir + DIR_W'(1));

  dwell_timer #(
    .CNT_W   (CNT_W),
    .RST_VAL (ALLRED_LD)
  ) u_dwell_timer (
    .i_clock    (i_clock),
    .i_reset    (i_reset),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .i_tick     (i_tick),
    .o_done     (w_done)
  );

  // Next-state, next-approach and dwell-reload decision; flash outranks expiry.
  always_comb begin
    w_next_state = r_state;
    w_next_dir   = r_dir;
    w_load       = 1'b0;
    w_load_val   = {CNT_W{1'b0}};
    if (i_flash) begin
      if (r_state != S_FLASH) begin
        w_next_state = S_FLASH;
        w_load       = 1'b1;
      end else begin
        w_next_state = S_FLASH;
      end
    end else begin
      case (r_state)
        S_GREEN: begin
          if (w_done) begin
            w_next_state = S_YELLOW;
            w_load       = 1'b1;
            w_load_val   = YELLOW_LD;
          end else begin
            w_next_state = S_GREEN;
          end
        end
        S_YELLOW: begin
          if (w_done) begin
            w_next_state = S_ALLRED;
            w_load       = 1'b1;
            w_load_val   = ALLRED_LD;
          end else begin
            w_next_state = S_YELLOW;
          end
        end
        S_ALLRED: begin
`ifdef TRAFFIC_PED_EN
          if (w_done && r_ped_pending) begin
            w_next_state = S_WALK;
            w_load       = 1'b1;
            w_load_val   = WALK_LD;
          end else if (w_done) begin
            w_next_state = S_GREEN;
            w_next_dir   = w_inc_dir;
            w_load       = 1'b1;
            w_load_val   = GREEN_LD;
          end else begin
            w_next_state = S_ALLRED;
          end
`else
          if (w_done) begin
            w_next_state = S_GREEN;
            w_next_dir   = w_inc_dir;
            w_load       = 1'b1;
            w_load_val   = GREEN_LD;
          end else begin
            w_next_state = S_ALLRED;
          end
`endif
        end
`ifdef TRAFFIC_PED_EN
        S_WALK: begin
          if (w_done) begin
            w_next_state = S_GREEN;
            w_next_dir   = w_inc_dir;
            w_load       = 1'b1;
            w_load_val   = GREEN_LD;
          end else begin
            w_next_state = S_WALK;
          end
        end
`endif
        S_FLASH: begin
          w_next_state = S_ALLRED;
          w_load       = 1'b1;
          w_load_val   = ALLRED_LD;
        end
        default: begin
          w_next_state = S_ALLRED;
          w_load       = 1'b1;
          w_load_val   = ALLRED_LD;
        end
      endcase
    end
  end

  // Blink phase: cleared on flash entry, toggled by each tick while flashing.
  always_comb begin
    w_next_blink = r_blink;
    if ((w_next_state == S_FLASH) && (r_state != S_FLASH)) begin
      w_next_blink = 1'b0;
    end else if ((r_state == S_FLASH) && i_tick) begin
      w_next_blink = ~r_blink;
    end else begin
      w_next_blink = r_blink;
    end
  end

  // Sequencer state plus registered lamp/walk outputs decoded from the next state.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state       <= S_ALLRED;
      r_dir         <= LAST_DIR;
      r_blink       <= 1'b0;
      r_light       <= {NUM_DIR{LAMP_RED}};
`ifdef TRAFFIC_PED_EN
      r_ped_pending <= 1'b0;
      r_walk        <= 1'b0;
`endif
    end else begin
      r_state       <= w_next_state;
      r_dir         <= w_next_dir;
      r_blink       <= w_next_blink;
      r_light       <= decode_light(w_next_state, w_next_dir, w_next_blink);
`ifdef TRAFFIC_PED_EN
      r_walk        <= (w_next_state == S_WALK);
      if ((r_state == S_ALLRED) && (w_next_state == S_WALK)) begin
        r_ped_pending <= 1'b0;
      end else if (i_ped_req && (r_state != S_WALK)) begin
        r_ped_pending <= 1'b1;
      end else begin
        r_ped_pending <= r_ped_pending;
      end
`endif
    end
  end

  assign o_light      = r_light;
  assign o_active_dir = r_dir;
  assign o_phase      = r_state;
`ifdef TRAFFIC_PED_EN
  assign o_walk       = r_walk;
`endif

endmodule

// File: tb/tb_traffic_lamp_seq.sv
// Self-checking bench for traffic_lamp_seq (NUM_DIR=3, GREEN=3, YELLOW=2,
// ALLRED=1, WALK=2). Expected outputs are queued as stimulus is driven and
// popped for comparison on the following falling edge.
module tb_traffic_lamp_seq;

  logic       clock = 1'b0;
  logic       reset;
  logic       tick;
  logic       flash;
  logic [8:0] light;
  logic [1:0] active_dir;
  logic [2:0] phase;
  logic       walk_obs;
`ifdef TRAFFIC_PED_EN
  logic       ped_req;
  logic       walk;
  assign walk_obs = walk;
`else
  assign walk_obs = 1'b0;
`endif

  always #5 clock = ~clock;

  traffic_lamp_seq #(
    .NUM_DIR      (3),
    .GREEN_TICKS  (3),
    .YELLOW_TICKS (2),
    .ALLRED_TICKS (1),
    .WALK_TICKS   (2)
  ) dut (
    .i_clock      (clock),
    .i_reset      (reset),
    .i_tick       (tick),
    .i_flash      (flash),
    .o_light      (light),
    .o_active_dir (active_dir),
    .o_phase      (phase)
`ifdef TRAFFIC_PED_EN
    ,
    .i_ped_req    (ped_req),
    .o_walk       (walk)
`endif
  );

  typedef struct packed {
    logic [8:0] light;
    logic [1:0] dir;
    logic [2:0] ph;
    logic       walk;
  } exp_t;

  typedef struct packed {
    logic rst;
    logic tk;
    logic fl;
    logic pr;
    exp_t e;
  } stim_t;

  stim_t stim_q[$];
  exp_t  sb_q[$];
  int    total = 0;
  int    bad   = 0;

  // Expected outputs for a phase code (0 allred,1 green,2 yellow,3 flash,4 walk).
  function automatic exp_t mk(input int ph, input int d, input logic bl);
    exp_t       r;
    logic [2:0] lamp;
    r.dir  = 2'(d);
    r.ph   = 3'(ph);
    r.walk = (ph == 4);
    r.light = 9'b000000000;
    for (int i = 0; i < 3; i++) begin
      case (ph)
        1:       lamp = (i == d) ? 3'b010 : 3'b100;
        2:       lamp = (i == d) ? 3'b001 : 3'b100;
        3:       lamp = bl ? 3'b001 : 3'b000;
        default: lamp = 3'b100;
      endcase
      r.light[3*i +: 3] = lamp;
    end
    return r;
  endfunction

  task automatic add(input logic rst, input logic tk, input logic fl, input logic pr,
                     input int ph, input int d, input logic bl, input int n);
    stim_t s;
    for (int k = 0; k < n; k++) begin
      s.rst = rst; s.tk = tk; s.fl = fl; s.pr = pr;
      s.e   = mk(ph, d, bl);
      stim_q.push_back(s);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; tick = 1'b1; flash = 1'b0;
`ifdef TRAFFIC_PED_EN
    ped_req = 1'b0;
`endif
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    exp_t got;
    exp_t want;
    reset = 1'b1; tick = 1'b1; flash = 1'b1;
`ifdef TRAFFIC_PED_EN
    ped_req = 1'b1;
`endif
    @(negedge clock);
    @(negedge clock);
    want = {9'b100100100, 2'd2, 3'd0, 1'b0};
    got  = {light, active_dir, phase, walk_obs};
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL reset: got light=%b dir=%0d phase=%0d walk=%b, expected light=%b dir=%0d phase=%0d walk=%b",
               got.light, got.dir, got.ph, got.walk, want.light, want.dir, want.ph, want.walk);
    end
    flash = 1'b0;
  endtask

  task automatic test_sequence();
    stim_t s; exp_t got; exp_t want; int step = 0;
    do_reset();
    add(0,1,0,0, 1,0,0,3); add(0,1,0,0, 2,0,0,2); add(0,1,0,0, 0,0,0,1);
    add(0,1,0,0, 1,1,0,3); add(0,1,0,0, 2,1,0,2); add(0,1,0,0, 0,1,0,1);
    add(0,1,0,0, 1,2,0,3); add(0,1,0,0, 2,2,0,2); add(0,1,0,0, 0,2,0,1);
    add(0,1,0,0, 1,0,0,3);
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      reset = s.rst; tick = s.tk; flash = s.fl;
      sb_q.push_back(s.e);
      @(negedge clock);
      want = sb_q.pop_front();
      got  = {light, active_dir, phase, walk_obs};
      total++;
      if (got !== want) begin
        bad++;
        $display("FAIL sequence step %0d: got light=%b dir=%0d phase=%0d walk=%b, expected light=%b dir=%0d phase=%0d walk=%b",
                 step, got.light, got.dir, got.ph, got.walk, want.light, want.dir, want.ph, want.walk);
      end
      step++;
    end
  endtask

  task automatic test_tick_gating();
    stim_t s; exp_t got; exp_t want; int step = 0;
    do_reset();
    add(0,1,0,0, 1,0,0,1); add(0,0,0,0, 1,0,0,5); add(0,1,0,0, 1,0,0,2);
    add(0,1,0,0, 2,0,0,1);
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      reset = s.rst; tick = s.tk; flash = s.fl;
      sb_q.push_back(s.e);
      @(negedge clock);
      want = sb_q.pop_front();
      got  = {light, active_dir, phase, walk_obs};
      total++;
      if (got !== want) begin
        bad++;
        $display("FAIL tick_gating step %0d: got light=%b dir=%0d phase=%0d walk=%b, expected light=%b dir=%0d phase=%0d walk=%b",
                 step, got.light, got.dir, got.ph, got.walk, want.light, want.dir, want.ph, want.walk);
      end
      step++;
    end
  endtask

  task automatic test_flash();
    stim_t s; exp_t got; exp_t want; int step = 0;
    do_reset();
    add(0,1,0,0, 1,0,0,2);
    add(0,1,1,0, 3,0,0,1); add(0,1,1,0, 3,0,1,1); add(0,1,1,0, 3,0,0,1);
    add(0,1,1,0, 3,0,1,1); add(0,0,1,0, 3,0,1,1);
    add(0,1,0,0, 0,0,0,1); add(0,1,0,0, 1,1,0,3);
    // flash on the last green cycle beats the dwell expiry
    add(0,1,1,0, 3,1,0,1); add(0,1,0,0, 0,1,0,1); add(0,1,0,0, 1,2,0,1);
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      reset = s.rst; tick = s.tk; flash = s.fl;
      sb_q.push_back(s.e);
      @(negedge clock);
      want = sb_q.pop_front();
      got  = {light, active_dir, phase, walk_obs};
      total++;
      if (got !== want) begin
        bad++;
        $display("FAIL flash step %0d: got light=%b dir=%0d phase=%0d walk=%b, expected light=%b dir=%0d phase=%0d walk=%b",
                 step, got.light, got.dir, got.ph, got.walk, want.light, want.dir, want.ph, want.walk);
      end
      step++;
    end
  endtask

  task automatic test_mid_reset();
    stim_t s; exp_t got; exp_t want; int step = 0;
    do_reset();
    add(0,1,0,0, 1,0,0,3); add(0,1,0,0, 2,0,0,2); add(0,1,0,0, 0,0,0,1);
    add(0,1,0,0, 1,1,0,3); add(0,1,0,0, 2,1,0,1);
    add(1,1,0,0, 0,2,0,1); add(0,1,0,0, 1,0,0,1);
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      reset = s.rst; tick = s.tk; flash = s.fl;
      sb_q.push_back(s.e);
      @(negedge clock);
      want = sb_q.pop_front();
      got  = {light, active_dir, phase, walk_obs};
      total++;
      if (got !== want) begin
        bad++;
        $display("FAIL mid_reset step %0d: got light=%b dir=%0d phase=%0d walk=%b, expected light=%b dir=%0d phase=%0d walk=%b",
                 step, got.light, got.dir, got.ph, got.walk, want.light, want.dir, want.ph, want.walk);
      end
      step++;
    end
    reset = 1'b0;
  endtask

`ifdef TRAFFIC_PED_EN
  task automatic test_ped();
    stim_t s; exp_t got; exp_t want; int step = 0;
    do_reset();
    add(0,1,0,0, 1,0,0,1); add(0,1,0,1, 1,0,0,1); add(0,1,0,0, 1,0,0,1);
    add(0,1,0,0, 2,0,0,2); add(0,1,0,0, 0,0,0,1);
    add(0,1,0,0, 4,0,0,1); add(0,1,0,1, 4,0,0,1);
    add(0,1,0,0, 1,1,0,3); add(0,1,0,0, 2,1,0,2); add(0,1,0,0, 0,1,0,1);
    add(0,1,0,0, 1,2,0,1);
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      reset = s.rst; tick = s.tk; flash = s.fl; ped_req = s.pr;
      sb_q.push_back(s.e);
      @(negedge clock);
      want = sb_q.pop_front();
      got  = {light, active_dir, phase, walk_obs};
      total++;
      if (got !== want) begin
        bad++;
        $display("FAIL ped step %0d: got light=%b dir=%0d phase=%0d walk=%b, expected light=%b dir=%0d phase=%0d walk=%b",
                 step, got.light, got.dir, got.ph, got.walk, want.light, want.dir, want.ph, want.walk);
      end
      step++;
    end
    ped_req = 1'b0;
  endtask
`endif

  initial begin
    reset = 1'b1; tick = 1'b0; flash = 1'b0;
`ifdef TRAFFIC_PED_EN
    ped_req = 1'b0;
`endif
    test_reset();
    test_sequence();
    test_tick_gating();
    test_flash();
    test_mid_reset();
`ifdef TRAFFIC_PED_EN
    test_ped();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
